muldiv_controller: RTL and testbench
====================================

MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, EXE-stage mult/div issue strobe.
REQ-004 SHALL have port Op, input, 2, 00 mult, 01 multu, 10 div, 11 divu; sampled with Start.
REQ-005 SHALL have ports Rs_data and Rt_data, input, 32 each, operands sampled with Start (Rs dividend/multiplicand).
REQ-006 SHALL have port Flush, input, 1, cancels a same-cycle Start or HILO_write.
REQ-007 SHALL have port HILO_read, input, 1, mfhi/mflo present in ID.
REQ-008 SHALL have port HILO_write, input, 2, 01 mtlo, 10 mthi, 00/11 none.
REQ-009 SHALL have port Write_data, input, 32, mthi/mtlo data.
REQ-010 SHALL have ports HI and LO, output, 32 each, registered result registers.
REQ-011 SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port Stall, output, 1, combinational pipeline stall request.
REQ-013 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port Div_zero, output, 1, last divide had Rt_data = 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX; Busy = (state != IDLE).
REQ-016 SHALL accept Start only when IDLE and Flush=0; at that edge latch operands (absolute values for signed ops), latch result signs, clear the 5-bit iteration counter, clear Div_zero, and enter CALC.
REQ-017 SHALL in CALC perform one radix-2 step per cycle (shift-add multiply, restoring divide) for exactly 32 cycles, then enter FIX.
REQ-018 SHALL in FIX apply sign correction (product negated if signs differ; quotient sign = sign(Rs) XOR sign(Rt); remainder sign = sign(Rs)), write HI (product[63:32] or remainder) and LO (product[31:0] or quotient) at the FIX->IDLE edge, and set Done for exactly one cycle.
REQ-019 SHALL make HI/LO valid and Done high 33 rising edges after the edge that accepts Start.
REQ-020 SHALL complete a divide by zero with normal latency, leave HI and LO unchanged, and set Div_zero at the same edge as Done; Div_zero holds until the next accepted Start.
REQ-021 SHALL produce LO = 0x80000000, HI = 0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-022 SHALL drive Stall = Busy AND (Start OR HILO_read OR HILO_write != 00), and ignore Start and HILO_write while Busy.
REQ-023 SHALL in IDLE with Flush=0 write Write_data to LO (01) or HI (10) at the clock edge; if Start and HILO_write coincide, SHALL accept Start and discard the write.
REQ-024 SHALL leave an in-progress operation unaffected by Flush.
REQ-025 SHALL make HI/LO observable by the pipeline in the Done cycle, so an mfhi/mflo stalled by REQ-022 reads the new value.

Reset
REQ-026 SHALL on Reset_n=0, immediately and regardless of clock, force state IDLE, counter 0, HI=0, LO=0, Busy=0, Done=0, Div_zero=0, including mid-CALC or in FIX.
REQ-027 SHALL resume normal operation at the first rising edge after Reset_n returns high.

Verification
REQ-028 SHALL verify mult 7 x 0xFFFFFFFD -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done high once, 33 edges after Start.
REQ-029 SHALL verify multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL verify div 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100 / 7 -> LO=14, HI=2; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 SHALL verify divu 5 / 0 with prior HI=0x11, LO=0x22 -> HI/LO unchanged, Div_zero=1 with Done.
REQ-032 SHALL verify HILO_read raised at CALC iteration 5 -> Stall=1 until Busy drops; a Start issued meanwhile is ignored; mtlo 0xABCD while IDLE -> LO=0xABCD next edge.
REQ-033 SHALL verify Reset_n pulsed low at CALC iteration 10 -> Busy=0, HI=LO=0 without a clock edge; a Start after release completes normally.

Source files
------------

// File: rtl/muldiv_controller.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO: result and Done 33 edges after an accepted Start.
// Backpressure: Stall is raised while busy if the pipeline presents a Start, an mfhi/mflo or an mthi/mtlo.
module muldiv_controller (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Rs_data,
  input  logic [31:0] Rt_data,
  input  logic        Flush,
  input  logic        HILO_read,
  input  logic [1:0]  HILO_write,
  input  logic [31:0] Write_data,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic        Div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        start_acc;
  logic        hilo_we;
  logic        is_signed;
  logic [31:0] rs_abs, rt_abs;
  logic [32:0] sum33;
  logic [32:0] shifted33;
  logic        ge;
  logic [63:0] prod;

  assign is_signed = ~Op[0];
  assign rs_abs    = (is_signed && Rs_data[31]) ? (32'd0 - Rs_data) : Rs_data;
  assign rt_abs    = (is_signed && Rt_data[31]) ? (32'd0 - Rt_data) : Rt_data;
  assign sum33     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
  assign shifted33 = {acc_hi_q, acc_lo_q[31]};
  assign ge        = (shifted33 >= {1'b0, opb_q});
  assign prod      = {acc_hi_q, acc_lo_q};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state_q != IDLE);
    Stall     = Busy && (Start || HILO_read || (HILO_write != 2'b00));
    start_acc = (state_q == IDLE) && Start && !Flush;
    hilo_we   = (state_q == IDLE) && !Start && !Flush &&
                ((HILO_write == 2'b01) || (HILO_write == 2'b10));
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          cnt_d    = 5'd0;
          dz_d     = 1'b0;
          is_div_d = Op[1];
          neg_lo_d = is_signed && (Rs_data[31] ^ Rt_data[31]);
          neg_hi_d = Op[1] ? (is_signed && Rs_data[31]) : neg_lo_d;
          acc_hi_d = 32'd0;
          acc_lo_d = Op[1] ? rs_abs : rt_abs;
          opb_d    = Op[1] ? rt_abs : rs_abs;
        end else if (hilo_we) begin
          if (HILO_write == 2'b01) lo_d = Write_data;
          else                     hi_d = Write_data;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          // restoring step: remainder always fits 32 bits, so a 32-bit subtract suffices
          acc_hi_d = ge ? (shifted33[31:0] - opb_q) : shifted33[31:0];
          acc_lo_d = {acc_lo_q[30:0], ge};
        end else begin
          acc_hi_d = sum33[32:1];
          acc_lo_d = {sum33[0], acc_lo_q[31:1]};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (is_div_q && (opb_q == 32'd0)) begin
          dz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_lo_q ? (32'd0 - acc_lo_q) : acc_lo_q;
          hi_d = neg_hi_q ? (32'd0 - acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? (64'd0 - prod) : prod;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q    <= 5'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Done     = done_q;
  assign Div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: vector table plus stall, flush, divide-by-zero and reset sequences.
module tb_muldiv_controller;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Rs_data, Rt_data;
  logic        Flush;
  logic        HILO_read;
  logic [1:0]  HILO_write;
  logic [31:0] Write_data;
  logic [31:0] HI, LO;
  logic        Busy, Stall, Done, Div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  muldiv_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .Flush(Flush),
    .HILO_read(HILO_read), .HILO_write(HILO_write), .Write_data(Write_data),
    .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall), .Done(Done), .Div_zero(Div_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one op and checks the exact 33-edge latency, result and the one-cycle Done pulse.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [1:0] hw,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    @(negedge Clk);
    Start = 1'b1; Op = op; Rs_data = rs; Rt_data = rt;
    HILO_write = hw; Write_data = 32'h99;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; HILO_write = 2'b00;
    chk({nm, "_busy_on"}, {31'd0, Busy}, 32'd1);
    chk({nm, "_dz_clr"}, {31'd0, Div_zero}, 32'd0);
    repeat (32) @(posedge Clk);
    @(negedge Clk);
    chk({nm, "_early_done"}, {31'd0, Done}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk({nm, "_done"}, {31'd0, Done}, 32'd1);
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
    chk({nm, "_dz"}, {31'd0, Div_zero}, {31'd0, edz});
    chk({nm, "_busy_off"}, {31'd0, Busy}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk({nm, "_done_pulse"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic stall_drop;

    vecs[0] = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[6] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[7] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

    Start = 0; Op = 0; Rs_data = 0; Rt_data = 0; Flush = 0;
    HILO_read = 0; HILO_write = 0; Write_data = 0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #2;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_dz", {31'd0, Div_zero}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, 2'b00,
             vecs[i].hi, vecs[i].lo, 1'b0);

    // mthi / mtlo while idle
    @(negedge Clk); HILO_write = 2'b10; Write_data = 32'h11;
    @(posedge Clk); @(negedge Clk);
    chk("mthi", HI, 32'h11);
    HILO_write = 2'b01; Write_data = 32'h22;
    @(posedge Clk); @(negedge Clk);
    chk("mtlo", LO, 32'h22);
    HILO_write = 2'b00;

    // flushed Start and flushed mtlo are dropped
    Start = 1'b1; Op = 2'b01; Rs_data = 3; Rt_data = 3; Flush = 1'b1;
    HILO_write = 2'b01; Write_data = 32'hDEAD;
    @(posedge Clk); @(negedge Clk);
    chk("flush_start", {31'd0, Busy}, 32'd0);
    chk("flush_mtlo", LO, 32'h22);
    Start = 1'b0; Flush = 1'b0; HILO_write = 2'b00;

    // divu 5/0 with a coincident mthi that must be discarded
    run_op("dz", 2'b11, 32'd5, 32'd0, 2'b10, 32'h11, 32'h22, 1'b1);

    // stall while busy: Start and mfhi/mflo raised at iteration 5, Flush mid-op
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; Rs_data = 32'h12345; Rt_data = 32'h10000;
    @(posedge Clk); @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    HILO_read = 1'b1; Start = 1'b1; Op = 2'b00; Rs_data = 99; Rt_data = 99; Flush = 1'b1;
    #1 chk("stall_it5", {31'd0, Stall}, 32'd1);
    @(posedge Clk); @(negedge Clk);
    Flush = 1'b0;
    @(posedge Clk); @(negedge Clk);
    Start = 1'b0;
    cyc = 0;
    stall_drop = 1'b0;
    while (Busy && cyc < 40) begin
      if (Stall !== 1'b1) stall_drop = 1'b1;
      @(posedge Clk); @(negedge Clk);
      cyc++;
    end
    chk("stall_held", {31'd0, stall_drop}, 32'd0);
    chk("stall_cycles", cyc, 32'd26);
    chk("stall_done", {31'd0, Done}, 32'd1);
    chk("stall_rel", {31'd0, Stall}, 32'd0);
    chk("stall_hi", HI, 32'h1);
    chk("stall_lo", LO, 32'h23450000);
    HILO_read = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("ignored_start", {31'd0, Busy}, 32'd0);

    HILO_write = 2'b01; Write_data = 32'hABCD;
    @(posedge Clk); @(negedge Clk);
    chk("mtlo_abcd", LO, 32'hABCD);
    HILO_write = 2'b00;

    // asynchronous reset at iteration 10
    Start = 1'b1; Op = 2'b00; Rs_data = 3; Rt_data = 4;
    @(posedge Clk); @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op("post_rst", 2'b01, 32'h10000, 32'h30000, 2'b00, 32'h3, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
